// File: rtl/shift2_packer_if.sv
// Digit-in / word-out handshake bundle for shift2_packer.
// master: digit source and word sink; slave: the packer.
interface shift2_packer_if #(
    parameter int SIZE = 8,
    parameter int CW   = $clog2(SIZE/2+1)
);
    logic            clear;
    logic [1:0]      din;
    logic            din_valid;
    logic            din_ready;
    logic            flush;
    logic [SIZE-1:0] dout;
    logic            dout_valid;
    logic            dout_ready;
    logic [CW-1:0]   dout_count;

    modport master (
        output clear, din, din_valid, flush, dout_ready,
        input  din_ready, dout, dout_valid, dout_count
    );

    modport slave (
        input  clear, din, din_valid, flush, dout_ready,
        output din_ready, dout, dout_valid, dout_count
    );
endinterface

// File: rtl/shift2_packer.sv
// Radix-4 digit assembler: 2-bit digits in, LSD first,
// packed into a SIZE-bit word with a valid/ready output.
module shift2_packer #(
    parameter int SIZE = 8,
    parameter int CW   = $clog2(SIZE/2+1)
) (
    input  logic           clk,
    input  logic           rst,
    shift2_packer_if.slave bus
);
    localparam int N = SIZE/2;
    localparam logic [CW-1:0] NC = CW'(N);

    typedef enum logic [1:0] {EMPTY, FILL, FULL} state_t;

    state_t          state;
    logic [SIZE-1:0] word;
    logic [CW-1:0]   count;
    logic [SIZE-1:0] dout_q;
    logic [CW-1:0]   cnt_q;
    logic            valid_q;

    logic            take;
    logic [SIZE-1:0] nword;
    logic [CW-1:0]   ncount;
    logic [CW-1:0]   gap;
    logic [SIZE-1:0] fword;

    assign bus.dout       = dout_q;
    assign bus.dout_count = cnt_q;
    assign bus.dout_valid = valid_q;
    assign bus.din_ready  = ~valid_q;

    // Word and count as they stand after this cycle's digit,
    // plus the right-aligned form used when flushing early.
    always_comb begin
        take   = bus.din_valid & ~valid_q;
        nword  = take ? {bus.din, word[SIZE-1:2]} : word;
        ncount = count + {{(CW-1){1'b0}}, take};
        gap    = NC - ncount;
        fword  = nword >> {gap, 1'b0};
    end

    // Fill / emit / handshake state machine.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= EMPTY;
            word    <= '0;
            count   <= '0;
            dout_q  <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
        end else if (bus.clear) begin
            state   <= EMPTY;
            count   <= '0;
            valid_q <= 1'b0;
        end else begin
            unique case (state)
                FULL: begin
                    if (bus.dout_ready) begin
                        valid_q <= 1'b0;
                        state   <= EMPTY;
                    end
                end
                default: begin
                    word <= nword;
                    if (ncount == NC) begin
                        dout_q  <= nword;
                        cnt_q   <= NC;
                        valid_q <= 1'b1;
                        count   <= '0;
                        state   <= FULL;
                    end else if (bus.flush && ncount != '0) begin
                        dout_q  <= fword;
                        cnt_q   <= ncount;
                        valid_q <= 1'b1;
                        count   <= '0;
                        state   <= FULL;
                    end else begin
                        count <= ncount;
                        state <= (ncount == '0) ? EMPTY : FILL;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_shift2_packer.sv
// Directed and random loopback bench for shift2_packer,
// with SIZE=8 and SIZE=16 instances.
module tb_shift2_packer;
    logic clk;
    logic rst;
    int   total;
    int   bad;

    shift2_packer_if #(.SIZE(8))  bus8 ();
    shift2_packer_if #(.SIZE(16)) bus16 ();

    shift2_packer #(.SIZE(8)) u8 (
        .clk (clk),
        .rst (rst),
        .bus (bus8)
    );

    shift2_packer #(.SIZE(16)) u16 (
        .clk (clk),
        .rst (rst),
        .bus (bus16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send8(input logic [1:0] d);
        bus8.din       = d;
        bus8.din_valid = 1'b1;
        tick();
    endtask

    logic [15:0] val8, val16;
    int          idx8, idx16;
    bit          busy8, busy16;
    int          sent8, sent16, recv8, recv16, cyc;
    logic [7:0]  q8[$];
    logic [15:0] q16[$];
    logic [15:0] exp_w;

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        bus8.clear = 0; bus8.din = 0; bus8.din_valid = 0;
        bus8.flush = 0; bus8.dout_ready = 1;
        bus16.clear = 0; bus16.din = 0; bus16.din_valid = 0;
        bus16.flush = 0; bus16.dout_ready = 1;
        #1;
        chk("rst_dout", bus8.dout, 0);
        chk("rst_valid", bus8.dout_valid, 0);
        chk("rst_ready", bus8.din_ready, 1);
        chk("rst_count", bus8.dout_count, 0);
        tick();
        tick();
        rst = 1'b0;
        tick();

        // full word
        send8(2'b11);
        send8(2'b10);
        send8(2'b01);
        chk("full_early_valid", bus8.dout_valid, 0);
        send8(2'b00);
        bus8.din_valid = 0;
        chk("full_valid", bus8.dout_valid, 1);
        chk("full_dout", bus8.dout, 8'h1B);
        chk("full_count", bus8.dout_count, 4);
        chk("full_din_ready", bus8.din_ready, 0);
        tick();
        chk("full_one_cycle", bus8.dout_valid, 0);
        chk("full_ready_back", bus8.din_ready, 1);

        // flush of a partial word
        send8(2'b11);
        send8(2'b01);
        bus8.din_valid = 0;
        bus8.flush = 1;
        tick();
        bus8.flush = 0;
        chk("flush_valid", bus8.dout_valid, 1);
        chk("flush_dout", bus8.dout, 8'h07);
        chk("flush_count", bus8.dout_count, 2);
        tick();
        bus8.flush = 1;
        tick();
        bus8.flush = 0;
        chk("flush_empty", bus8.dout_valid, 0);

        // flush together with the last digit
        send8(2'b11);
        send8(2'b01);
        send8(2'b10);
        bus8.flush = 1;
        send8(2'b00);
        bus8.flush = 0;
        bus8.din_valid = 0;
        chk("flushdig_dout", bus8.dout, 8'h27);
        chk("flushdig_count", bus8.dout_count, 4);
        tick();

        // backpressure
        bus8.dout_ready = 0;
        send8(2'b10);
        send8(2'b11);
        send8(2'b00);
        send8(2'b01);
        chk("bp_valid", bus8.dout_valid, 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp_dout", bus8.dout, 8'h4E);
            chk("bp_count", bus8.dout_count, 4);
            chk("bp_din_ready", bus8.din_ready, 0);
        end
        bus8.dout_ready = 1;
        tick();
        chk("bp_release", bus8.dout_valid, 0);
        tick();
        send8(2'b00);
        send8(2'b00);
        send8(2'b00);
        bus8.din_valid = 0;
        chk("bp_next_dout", bus8.dout, 8'h01);
        chk("bp_next_count", bus8.dout_count, 4);
        tick();

        // clear drops a partial word
        send8(2'b11);
        send8(2'b11);
        bus8.clear = 1;
        send8(2'b10);
        bus8.clear = 0;
        chk("clr_valid", bus8.dout_valid, 0);
        send8(2'b00);
        send8(2'b00);
        send8(2'b00);
        send8(2'b11);
        bus8.din_valid = 0;
        chk("clr_dout", bus8.dout, 8'hC0);
        chk("clr_count", bus8.dout_count, 4);
        tick();

        // async reset mid-fill
        send8(2'b01);
        send8(2'b10);
        bus8.din_valid = 0;
        #2;
        rst = 1'b1;
        #1;
        chk("arst_dout", bus8.dout, 0);
        chk("arst_valid", bus8.dout_valid, 0);
        chk("arst_ready", bus8.din_ready, 1);
        chk("arst_count", bus8.dout_count, 0);
        tick();
        rst = 1'b0;
        send8(2'b01);
        bus8.din_valid = 0;
        bus8.flush = 1;
        tick();
        bus8.flush = 0;
        chk("arst_lost_dout", bus8.dout, 8'h01);
        chk("arst_lost_count", bus8.dout_count, 1);
        tick();
        chk("arst_drain", bus8.dout_valid, 0);

        // random loopback from a 2-bit right-shift serializer
        busy8 = 0; busy16 = 0;
        sent8 = 0; sent16 = 0; recv8 = 0; recv16 = 0;
        idx8 = 0; idx16 = 0;
        val8 = 0; val16 = 0;
        cyc = 0;
        while ((recv8 < 1000 || recv16 < 1000) && cyc < 60000) begin
            if (!busy8 && sent8 < 1000) begin
                val8 = 16'($urandom_range(0, 255));
                idx8 = 0;
                busy8 = 1;
                q8.push_back(val8[7:0]);
            end
            if (!busy16 && sent16 < 1000) begin
                val16 = 16'($urandom);
                idx16 = 0;
                busy16 = 1;
                q16.push_back(val16);
            end
            bus8.din        = val8[2*idx8 +: 2];
            bus8.din_valid  = busy8;
            bus8.dout_ready = 1'($urandom_range(0, 1));
            bus16.din        = val16[2*idx16 +: 2];
            bus16.din_valid  = busy16;
            bus16.dout_ready = 1'($urandom_range(0, 1));
            #1;
            if (bus8.dout_valid && bus8.dout_ready) begin
                exp_w = (q8.size() > 0) ? {8'h0, q8.pop_front()} : 16'hFFFF;
                chk("loop8_dout", bus8.dout, exp_w);
                chk("loop8_count", bus8.dout_count, 4);
                recv8++;
            end
            if (bus16.dout_valid && bus16.dout_ready) begin
                exp_w = (q16.size() > 0) ? q16.pop_front() : ~bus16.dout;
                chk("loop16_dout", bus16.dout, exp_w);
                chk("loop16_count", bus16.dout_count, 8);
                recv16++;
            end
            if (bus8.din_valid && bus8.din_ready) begin
                idx8++;
                if (idx8 == 4) begin
                    busy8 = 0;
                    sent8++;
                end
            end
            if (bus16.din_valid && bus16.din_ready) begin
                idx16++;
                if (idx16 == 8) begin
                    busy16 = 0;
                    sent16++;
                end
            end
            tick();
            cyc++;
        end
        chk("loop8_words", recv8, 1000);
        chk("loop16_words", recv16, 1000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
